mic1_alu_pipe: RTL

MIC1_ALU_PIPE -- requirements
Module: mic1_alu_pipe

---
 rtl/mic1_alu_pkg.sv | 38 +++
 rtl/mic1_alu_core.sv | 73 +++++++
 rtl/mic1_alu_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mic1_alu_pkg.sv
// Shared definitions for the MIC-1 style ALU pipeline.
// Contents: bit positions inside the 8-bit select word, the control FSM
// state type, the ALU function codes ({F0,F1}) and the shifter codes
// ({SLL8,SRA1}).
package mic1_alu_pkg;

   // select = {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}, bit 7 down to bit 0
   localparam int unsigned SEL_INC  = 0;
   localparam int unsigned SEL_INVA = 1;
   localparam int unsigned SEL_ENB  = 2;
   localparam int unsigned SEL_ENA  = 3;
   localparam int unsigned SEL_F1   = 4;
   localparam int unsigned SEL_F0   = 5;
   localparam int unsigned SEL_SRA1 = 6;
   localparam int unsigned SEL_SLL8 = 7;

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

   // Function code is {F0,F1}
   typedef enum logic [1:0] {
      FN_AND  = 2'b00,
      FN_OR   = 2'b01,
      FN_NOTB = 2'b10,
      FN_ADD  = 2'b11
   } fn_t;

   // Shifter code is {SLL8,SRA1}
   typedef enum logic [1:0] {
      SH_PASS = 2'b00,
      SH_SRA1 = 2'b01,
      SH_SLL8 = 2'b10,
      SH_BAD  = 2'b11
   } shift_t;

endpackage

// File: rtl/mic1_alu_core.sv
// Combinational ALU core: operand enable/invert, logic/add function,
// flags and shifter.
// Ports:
//   a_in, b_in : operands (WIDTH)
//   sel        : {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}
//   result     : shifted ALU value (WIDTH)
//   n, z       : negative / zero of the unshifted ALU value
//   c, v       : adder carry-out / signed overflow (0 unless adding)
//   err        : SLL8 and SRA1 both requested
module mic1_alu_core
   import mic1_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [7:0]       sel,
   output logic [WIDTH-1:0] result,
   output logic             n,
   output logic             z,
   output logic             c,
   output logic             v,
   output logic             err
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] value;
   logic [WIDTH:0]   sum;
   fn_t              fn;
   shift_t           sh;

   always_comb begin
      a = sel[SEL_ENA] ? a_in : '0;
      b = sel[SEL_ENB] ? b_in : '0;
      if (sel[SEL_INVA]) a = ~a;

      fn  = fn_t'({sel[SEL_F0], sel[SEL_F1]});
      sh  = shift_t'({sel[SEL_SLL8], sel[SEL_SRA1]});
      sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, sel[SEL_INC]};

      value = '0;
      c     = 1'b0;
      v     = 1'b0;
      case (fn)
         FN_AND:  value = a & b;
         FN_OR:   value = a | b;
         FN_NOTB: value = ~b;
         FN_ADD: begin
            value = sum[WIDTH-1:0];
            c     = sum[WIDTH];
            // Overflow: operands share a sign that the result does not
            v     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         default: value = '0;
      endcase

      n = value[WIDTH-1];
      z = (value == '0);

      err = 1'b0;
      case (sh)
         SH_SRA1: result = {value[WIDTH-1], value[WIDTH-1:1]};
         SH_SLL8: result = {value[WIDTH-9:0], 8'h00};
         SH_BAD: begin
            result = value;
            err    = 1'b1;
         end
         default: result = value;
      endcase
   end

endmodule

// File: rtl/mic1_alu_pipe.sv
// Registered ALU stage with an optional iterative (shift-add) multiplier
// and valid/ready handshakes on both sides.
// Ports:
//   clk, reset           : clock (rising edge), async active-high reset
//   in_valid, in_ready   : operation offer / accept
//   A, B, select, mul    : operands, ALU select word, multiply request
//   out, N, Z, C, V, err : registered result and flags
//   out_valid, out_ready : result offer / consume
module mic1_alu_pipe
   import mic1_alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned MUL_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [7:0]       select,
   input  logic             mul,
   output logic [WIDTH-1:0] out,
   output logic             N,
   output logic             Z,
   output logic             C,
   output logic             V,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] core_result;
   logic             core_n;
   logic             core_z;
   logic             core_c;
   logic             core_v;
   logic             core_err;
   logic             accept;
   logic             mul_go;
   logic [WIDTH-1:0] mul_step;

   mic1_alu_core #(.WIDTH(WIDTH)) u_core (
      .a_in   (A),
      .b_in   (B),
      .sel    (select),
      .result (core_result),
      .n      (core_n),
      .z      (core_z),
      .c      (core_c),
      .v      (core_v),
      .err    (core_err)
   );

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign mul_go   = accept && mul && (MUL_EN != 0);
   assign mul_step = acc + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out       <= '0;
         N         <= 1'b0;
         Z         <= 1'b0;
         C         <= 1'b0;
         V         <= 1'b0;
         err       <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (mul_go) begin
                  state  <= MUL;
                  mcand  <= A;
                  mplier <= B;
                  acc    <= '0;
                  count  <= '0;
               end else if (accept) begin
                  out       <= core_result;
                  N         <= core_n;
                  Z         <= core_z;
                  C         <= core_c;
                  V         <= core_v;
                  err       <= core_err;
                  out_valid <= 1'b1;
               end
            end
            MUL: begin
               // One multiplier bit per cycle; the final step's sum is the
               // product, so it is loaded directly into the output register.
               acc    <= mul_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (count == CW'(WIDTH - 1)) begin
                  state     <= IDLE;
                  out       <= mul_step;
                  N         <= mul_step[WIDTH-1];
                  Z         <= (mul_step == '0);
                  C         <= 1'b0;
                  V         <= 1'b0;
                  err       <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
